// File: rtl/timing_register_bank_n_pkg.sv
// rtl/timing_register_bank_n_pkg.sv - shared types, constants and BCD conversion for the timing register bank
package timing_register_bank_n_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2,
        CONVERT = 2'd3
    } state_t;

    localparam int          BCD_DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX     = 4'd9;

    // Up to 16 BCD digits, digit 0 in bits [3:0]; callers truncate to their own binary width.
    function automatic logic [31:0] bcd_to_bin(input logic [63:0] bcd, input int digits);
        logic [31:0] acc;
        acc = '0;
        for (int k = digits - 1; k >= 0; k--) begin
            acc = acc * 32'd10 + {28'd0, bcd[k*BCD_DIGIT_W +: BCD_DIGIT_W]};
        end
        return acc;
    endfunction

endpackage

// File: rtl/bcd_channel_reg.sv
// rtl/bcd_channel_reg.sv - one timing channel: BCD shadow copy with digit writes, active copy with load/revert
module bcd_channel_reg
    import timing_register_bank_n_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int DIG_W  = 1,
    parameter logic [DIGITS*BCD_DIGIT_W-1:0] INIT = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_en,
    input  logic [DIG_W-1:0]                wr_digit,
    input  logic [BCD_DIGIT_W-1:0]          wr_data,
    input  logic                            revert,
    input  logic                            load,
    output logic [DIGITS*BCD_DIGIT_W-1:0]   shadow,
    output logic [DIGITS*BCD_DIGIT_W-1:0]   active
);

    // Shadow takes digit writes or is restored from active; active only changes on load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= INIT;
            active <= INIT;
        end else begin
            if (revert) begin
                shadow <= active;
            end else if (wr_en) begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (wr_digit == DIG_W'(k)) begin
                        shadow[k*BCD_DIGIT_W +: BCD_DIGIT_W] <= wr_data;
                    end
                end
            end
            if (load) begin
                active <= shadow;
            end
        end
    end

endmodule

// File: rtl/timing_register_bank_n.sv
// rtl/timing_register_bank_n.sv - parametrised BCD timing bank with safe-point commit; option COMMIT_TIMEOUT_EN
module timing_register_bank_n
    import timing_register_bank_n_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DIGITS      = 2,
    parameter int BIN_W       = 7,
    parameter logic [NUM_CH*DIGITS*BCD_DIGIT_W-1:0] INIT_BCD = 24'h031530,
    parameter int MIN_VAL     = 1,
    parameter int TIMEOUT_CYC = 1024,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [DIG_W-1:0]        wr_digit,
    input  logic [3:0]              wr_data,
    output logic                    wr_ack,
    output logic                    err_bcd,
    input  logic                    commit_req,
    input  logic                    safe_point,
    output logic                    busy,
    output logic                    commit_done,
    output logic                    err_range,
    output logic                    err_timeout,
    output logic [NUM_CH*BIN_W-1:0] bin_out
);

    localparam int CW = DIGITS * BCD_DIGIT_W;

    function automatic logic [NUM_CH*BIN_W-1:0] init_bin();
        logic [NUM_CH*BIN_W-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            v[c*BIN_W +: BIN_W] = BIN_W'(bcd_to_bin(64'(INIT_BCD[c*CW +: CW]), DIGITS));
        end
        return v;
    endfunction

    localparam logic [NUM_CH*BIN_W-1:0] INIT_BIN = init_bin();

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end
    if ((64'd1 << BIN_W) <= 64'(10 ** DIGITS - 1)) begin : g_bad_bin_w
        $error("BIN_W too narrow for DIGITS");
    end

    state_t                   state, state_nx;
    logic                     wr_valid, wr_ok, wr_bad;
    logic                     load, revert, range_fail, convert, range_ok;
    logic [BIN_W-1:0]         sb;
    logic [NUM_CH*CW-1:0]     shadow_all, active_all;
    logic [NUM_CH*BIN_W-1:0]  active_bin;

    // Writes are only considered while idle; invalid ones flag err_bcd instead of touching the shadow.
    always_comb begin
        wr_valid = (wr_data <= BCD_MAX) && (int'(wr_ch) < NUM_CH) && (int'(wr_digit) < DIGITS);
        wr_ok    = (state == IDLE) && wr_en && wr_valid;
        wr_bad   = (state == IDLE) && wr_en && !wr_valid;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        bcd_channel_reg #(
            .DIGITS (DIGITS),
            .DIG_W  (DIG_W),
            .INIT   (INIT_BCD[i*CW +: CW])
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (wr_ok && (wr_ch == CH_W'(i))),
            .wr_digit (wr_digit),
            .wr_data  (wr_data),
            .revert   (revert),
            .load     (load),
            .shadow   (shadow_all[i*CW +: CW]),
            .active   (active_all[i*CW +: CW])
        );
    end

    // Binary views: shadow values for the minimum check, active values for publication.
    always_comb begin
        range_ok   = 1'b1;
        sb         = '0;
        active_bin = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sb = BIN_W'(bcd_to_bin(64'(shadow_all[c*CW +: CW]), DIGITS));
            if (int'(sb) < MIN_VAL) begin
                range_ok = 1'b0;
            end
            active_bin[c*BIN_W +: BIN_W] = BIN_W'(bcd_to_bin(64'(active_all[c*CW +: CW]), DIGITS));
        end
    end

`ifdef COMMIT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
    logic            timeout_hit;

    // Counts cycles spent waiting for a safe point; cleared whenever the wait ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state == PENDING) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    // Registered abort pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Commit sequencing: wait for safe point, validate and copy, then publish.
    always_comb begin
        state_nx   = state;
        load       = 1'b0;
        revert     = 1'b0;
        range_fail = 1'b0;
        convert    = 1'b0;
`ifdef COMMIT_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (commit_req) state_nx = PENDING;
            end
            PENDING: begin
                if (safe_point) begin
                    state_nx = APPLY;
`ifdef COMMIT_TIMEOUT_EN
                end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    revert      = 1'b1;
                    timeout_hit = 1'b1;
                    state_nx    = IDLE;
`endif
                end
            end
            APPLY: begin
                if (range_ok) begin
                    load     = 1'b1;
                    state_nx = CONVERT;
                end else begin
                    revert     = 1'b1;
                    range_fail = 1'b1;
                    state_nx   = IDLE;
                end
            end
            CONVERT: begin
                convert  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Registered pulses, sticky write error and the published binary values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ack      <= 1'b0;
            commit_done <= 1'b0;
            err_range   <= 1'b0;
            err_bcd     <= 1'b0;
            bin_out     <= INIT_BIN;
        end else begin
            wr_ack      <= wr_ok;
            commit_done <= convert;
            err_range   <= range_fail;
            if (wr_bad) begin
                err_bcd <= 1'b1;
            end else if ((state == IDLE) && commit_req) begin
                err_bcd <= 1'b0;
            end
            if (convert) begin
                bin_out <= active_bin;
            end
        end
    end

endmodule

// File: tb/tb_timing_register_bank_n.sv
// tb/tb_timing_register_bank_n.sv - self-checking bench for timing_register_bank_n
module tb_timing_register_bank_n;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [0:0]  wr_digit = '0;
    logic [3:0]  wr_data = '0;
    logic        commit_req = 1'b0;
    logic        safe_point = 1'b0;
    logic        wr_ack, err_bcd, busy, commit_done, err_range, err_timeout;
    logic [20:0] bin_out;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int rng_cnt = 0;

    timing_register_bank_n dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_digit(wr_digit),
        .wr_data(wr_data), .wr_ack(wr_ack), .err_bcd(err_bcd), .commit_req(commit_req),
        .safe_point(safe_point), .busy(busy), .commit_done(commit_done),
        .err_range(err_range), .err_timeout(err_timeout), .bin_out(bin_out)
    );

    always #5 clk = ~clk;

    // Reference model: channel values as decimal integers.
    int m_sh[3], m_act[3], m_bin[3];
    int m_phase;
    bit m_ack, m_done, m_rng, m_errbcd;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_sh = '{30, 15, 3}; m_act = '{30, 15, 3}; m_bin = '{30, 15, 3};
            m_phase = 0; m_ack = 0; m_done = 0; m_rng = 0; m_errbcd = 0;
        end else begin
            bit bad;
            int p;
            bad = 0; m_ack = 0; m_done = 0; m_rng = 0;
            case (m_phase)
                0: begin
                    if (wr_en) begin
                        if (wr_data <= 9 && wr_ch < 3) begin
                            p = (wr_digit == 0) ? 1 : 10;
                            m_sh[wr_ch] = m_sh[wr_ch] - ((m_sh[wr_ch] / p) % 10) * p + int'(wr_data) * p;
                            m_ack = 1;
                        end else bad = 1;
                    end
                    if (commit_req) begin m_errbcd = 0; m_phase = 1; end
                    if (bad) m_errbcd = 1;
                end
                1: if (safe_point) m_phase = 2;
                2: begin
                    if (m_sh[0] >= 1 && m_sh[1] >= 1 && m_sh[2] >= 1) begin
                        m_act = m_sh; m_phase = 3;
                    end else begin
                        m_sh = m_act; m_rng = 1; m_phase = 0;
                    end
                end
                default: begin m_bin = m_act; m_done = 1; m_phase = 0; end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [20:0] pack3(input int a, input int b, input int c);
        return {7'(c), 7'(b), 7'(a)};
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset) begin
            chk("bin_out", 32'(bin_out), 32'(pack3(m_bin[0], m_bin[1], m_bin[2])));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("wr_ack", 32'(wr_ack), 32'(m_ack));
            chk("commit_done", 32'(commit_done), 32'(m_done));
            chk("err_range", 32'(err_range), 32'(m_rng));
            chk("err_bcd", 32'(err_bcd), 32'(m_errbcd));
            chk("err_timeout", 32'(err_timeout), 32'd0);
            if (commit_done) done_cnt++;
            if (err_range) rng_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int ch, input int dig, input int data);
        wr_en = 1; wr_ch = 2'(ch); wr_digit = 1'(dig); wr_data = 4'(data);
        tick();
        wr_en = 0;
    endtask

    task automatic commit(input int gap);
        commit_req = 1;
        tick();
        commit_req = 0;
        repeat (gap) tick();
        safe_point = 1;
        tick();
        safe_point = 0;
        repeat (4) tick();
    endtask

    initial begin
        int d0;
        repeat (3) tick();
        reset = 1;
        tick();
        chk("lit_reset_bin", 32'(bin_out), 32'(pack3(30, 15, 3)));
        chk("lit_reset_busy", 32'(busy), 32'd0);
        chk("lit_reset_errbcd", 32'(err_bcd), 32'd0);

        // ch1 <- 42, safe point three cycles after the request
        wr(1, 0, 2); wr(1, 1, 4);
        d0 = done_cnt;
        commit(2);
        chk("lit_ch1_42", 32'(bin_out[13:7]), 32'd42);
        chk("lit_ch0_30", 32'(bin_out[6:0]), 32'd30);
        chk("lit_ch2_3", 32'(bin_out[20:14]), 32'd3);
        chk("lit_done_once", 32'(done_cnt - d0), 32'd1);

        // invalid digit and invalid channel are rejected
        wr(0, 0, 10); tick();
        chk("lit_errbcd_set", 32'(err_bcd), 32'd1);
        wr(3, 0, 5); tick();
        wr(0, 1, 9); wr(0, 0, 0);    // boundary digit 9 -> ch0 = 90
        commit(0);
        chk("lit_errbcd_clr", 32'(err_bcd), 32'd0);
        chk("lit_ch0_90", 32'(bin_out[6:0]), 32'd90);

        // ch2 <- 00 violates the minimum; shadow must revert to 03
        wr(2, 0, 0); wr(2, 1, 0);
        d0 = rng_cnt;
        commit(1);
        chk("lit_range_pulse", 32'(rng_cnt - d0), 32'd1);
        chk("lit_ch2_kept", 32'(bin_out[20:14]), 32'd3);
        d0 = done_cnt;
        commit(0);
        chk("lit_revert_commit", 32'(done_cnt - d0), 32'd1);
        chk("lit_ch2_still3", 32'(bin_out[20:14]), 32'd3);

        // writes while pending are dropped
        wr(0, 0, 7);                  // shadow ch0 = 97
        commit_req = 1; tick(); commit_req = 0;
        wr(0, 0, 5); tick();
        safe_point = 1; tick(); safe_point = 0;
        repeat (4) tick();
        chk("lit_pending_drop", 32'(bin_out[6:0]), 32'd97);
        commit(0);
        chk("lit_pending_drop2", 32'(bin_out[6:0]), 32'd97);

        // async reset while in APPLY loses the commit and restores INIT
        wr(0, 1, 4); wr(0, 0, 5);
        commit_req = 1; tick(); commit_req = 0;
        safe_point = 1; tick(); safe_point = 0;
        reset = 0;
        #1;
        chk("lit_rst_apply_bin", 32'(bin_out), 32'(pack3(30, 15, 3)));
        tick(); tick();
        reset = 1;
        tick();
        chk("lit_rst_busy", 32'(busy), 32'd0);
        commit(0);
        chk("lit_rst_shadow", 32'(bin_out), 32'(pack3(30, 15, 3)));

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timing_register_bank_n.md
Name: timing_register_bank_n

Overview:
Parametrised successor to the fixed three-phase traffic-light time register bank. Holds NUM_CH timing values, each DIGITS BCD digits wide, and outputs each as binary to the light controller.
Digit writes go to a shadow copy. A commit copies the shadow to the active copy atomically, and only at a controller safe point, so a phase time never changes mid-cycle. BCD digit and minimum-value checks are built in.

Parameters:
NUM_CH, 3, number of timing channels (ch0 main green, ch1 secondary green, ch2 amber)
DIGITS, 2, BCD digits per channel
BIN_W, 7, binary output width per channel; must satisfy 2^BIN_W > 10^DIGITS - 1
INIT_BCD, {8'h03,8'h15,8'h30}, packed reset values, ch0 in LSBs: ch0=30, ch1=15, ch2=03
MIN_VAL, 1, smallest committable binary value per channel
TIMEOUT_CYC, 1024, safe-point wait limit; used only with COMMIT_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  digit write strobe, one cycle per digit
wr_ch  in  $clog2(NUM_CH)  target channel
wr_digit  in  $clog2(DIGITS)  digit index, 0 = units
wr_data  in  4  BCD digit
wr_ack  out  1  pulse: digit accepted into shadow
err_bcd  out  1  sticky: a write was rejected
commit_req  in  1  request to apply shadow to active
safe_point  in  1  controller at cycle boundary, commit allowed
busy  out  1  state != IDLE
commit_done  out  1  pulse: bin_out now shows the new values
err_range  out  1  pulse: commit rejected on range
err_timeout  out  1  pulse: commit aborted on timeout (0 when feature is off)
bin_out  out  NUM_CH*BIN_W  active values in binary, ch0 in LSBs

Behaviour:
- Reset (reset=0, async): shadow=active=INIT_BCD; bin_out=binary(INIT_BCD) (30/15/3); state IDLE; all pulses 0; err_bcd=0.
- Write, IDLE only. Accepted when wr_en=1, wr_data<=9, wr_ch<NUM_CH and wr_digit<DIGITS.
  - Accepted: shadow digit updated at the clock edge; wr_ack high in the next cycle.
  - Rejected: shadow unchanged; err_bcd set. err_bcd clears only on the next accepted commit_req.
  - Outside IDLE: wr_en is dropped silently, with no ack and no err_bcd.
- FSM states: IDLE, PENDING, APPLY, CONVERT.
  - IDLE: commit_req=1 -> PENDING. safe_point is not sampled in IDLE, even if it arrives with commit_req.
  - PENDING: safe_point=1 -> APPLY. commit_req is ignored.
  - APPLY (1 cycle): each channel's shadow is converted to binary and compared with MIN_VAL.
    - All channels >= MIN_VAL: active<=shadow, then -> CONVERT.
    - Any channel < MIN_VAL: shadow<=active (revert), err_range pulses next cycle, -> IDLE, bin_out unchanged.
  - CONVERT (1 cycle): bin_out<=binary(active); commit_done pulses next cycle; -> IDLE.
- Latency: commit_req at edge t, safe_point at edge t+1 -> bin_out new and commit_done=1 in the cycle after edge t+3.
- Conversion rule: sum(digit_k * 10^k), truncated to BIN_W bits. Zero-extend if narrower.
- Wr_en together with commit_req in IDLE: the write is applied first and is included in the commit.
- Reset mid-commit: everything returns to the INIT values; a pending commit is lost.

Optional Feature:
COMMIT_TIMEOUT_EN
- Defined: a counter runs while in PENDING. After TIMEOUT_CYC cycles without safe_point: shadow<=active, err_timeout pulses, -> IDLE.
- Undefined: PENDING waits indefinitely; err_timeout is tied to 0 and the counter is absent.

Decomposition:
- Shared package holds:
  - state enum (IDLE/PENDING/APPLY/CONVERT);
  - BCD_DIGIT_W=4 and BCD_MAX=9;
  - function bcd_to_bin(DIGITS, BIN_W).
- One natural sub-module: bcd_channel_reg, a per-channel shadow/active pair with digit write, revert and load controls, instantiated NUM_CH times via generate.

Test Plan:
- Reset release -> bin_out ch0=30, ch1=15, ch2=3; busy=0; err_bcd=0.
- Write ch1 digits 4,2 (units=2, tens=4) then commit_req; safe_point 3 cycles later -> ch1=42, commit_done exactly once, ch0 and ch2 unchanged.
- Write wr_data=4'hA to ch0 -> no wr_ack, err_bcd=1, shadow unchanged; the next commit_req clears err_bcd.
- Write ch2=00 then commit with safe_point -> err_range pulse, bin_out ch2 stays 3, shadow reverts to 03.
- wr_en while PENDING -> ignored; the commit applies the pre-PENDING shadow. Async reset asserted in APPLY -> INIT values restored.
- With COMMIT_TIMEOUT_EN, TIMEOUT_CYC=8, no safe_point -> err_timeout after 8 PENDING cycles, bin_out unchanged, back to IDLE.
